skeleton_mac: RTL and testbench
===============================

// Module: skeleton_mac
// PURPOSE
//  Parametrised on-device test skeleton for a pipelined signed multiply-accumulate DUT.
//  The host writes NUM_PAIRS operand pairs over the ADR/RnW bus and fires TRGG_START_CALC.
//  The block streams one pair per cycle into the DUT, accumulates the products and counts busy cycles.
//  Accumulator, cycle count and status are read back over the same bus.
// PARAMETERS
//  BITWIDTH_IN    8   operand width, signed two's complement
//  BITWIDTH_SYS   16  device data bus width (>= BITWIDTH_IN)
//  BITWIDTH_HEAD  26  metadata width
//  BITWIDTH_ADR   6   address width; 2*NUM_PAIRS must be <= 2**BITWIDTH_ADR
//  NUM_PAIRS      8   operand pairs per run (1..31)
//  BITWIDTH_ACC   16  accumulator width (<= 31); ACC_WORDS = ceil(BITWIDTH_ACC/BITWIDTH_SYS)
//  MULT_PIPE      2   register stages inside the multiplier (>= 1)
// PORTS
//  CLK_SYS          in   1              system clock, rising edge
//  RSTN             in   1              asynchronous active-low reset
//  EN               in   1              block enable; low = synchronous clear to IDLE
//  TRGG_START_CALC  in   1              start pulse; sampled only in IDLE
//  RnW              in   1              1 = read, 0 = write
//  ADR              in   BITWIDTH_ADR   register/RAM address
//  DATA_IN          in   BITWIDTH_SYS   write data; operand is MSB-aligned: DATA_IN[SYS-1 -: IN]
//  DATA_OUT         out  BITWIDTH_SYS   registered read data
//  DATA_HEAD        out  BITWIDTH_HEAD  {4'd5, (2*NUM_PAIRS)[5:0], 6'd1, BITWIDTH_IN[4:0], BITWIDTH_ACC[4:0]}
//  RDY              out  1              high only in IDLE
// BEHAVIOUR
//  - Reset (RSTN=0, async): state=IDLE, RDY=1, DATA_OUT=0, acc=0, cycle count=0, ovf=0, operand RAM=0.
//  - EN=0 at a clock edge gives the same cleared state, synchronously.
//  - Write map (RnW=0, IDLE only):
//      ADR 0..N-1  -> operand A[ADR]
//      ADR N..2N-1 -> operand B[ADR-N]
//      Other addresses and writes outside IDLE are ignored.
//  - Read map (RnW=1, any state; DATA_OUT valid 1 cycle after ADR is presented):
//      ADR 0..ACC_WORDS-1 -> accumulator, sign-extended, LS word at ADR 0
//      ADR ACC_WORDS      -> busy cycle count, zero-extended
//      ADR ACC_WORDS+1    -> {0.., ovf}
//      Any other address  -> 0
//  - FSM:
//      IDLE --TRGG_START_CALC--> ISSUE. On entry to ISSUE: acc, count and ovf clear; pair index = 0.
//      ISSUE: one pair per cycle into the DUT; after pair N-1 -> DRAIN.
//      DRAIN: MULT_PIPE+1 cycles while the last product accumulates -> IDLE.
//  - RDY is low for exactly NUM_PAIRS+MULT_PIPE+1 cycles. Count equals that value at completion.
//  - A trigger outside IDLE is ignored. A trigger on the completion edge is ignored; the block re-arms next cycle.
//  - Arithmetic:
//      product = signed 2*BITWIDTH_IN bits.
//      acc_next = acc + sext(product) at BITWIDTH_ACC+1 bits.
//      ovf is sticky if acc_next is out of BITWIDTH_ACC signed range.
//  - A valid bit travels with each product; the accumulator adds only valid products.
// CONFIGURATION
//  SKELETON_MAC_SATURATE_EN
//    defined:   on overflow, acc clamps to +2^(ACC-1)-1 or -2^(ACC-1) and stays clamped until the next add
//               brings it back into range; ovf is set.
//    undefined: acc wraps modulo 2^BITWIDTH_ACC; ovf is still set.
// STRUCTURE
//  - Package skeleton_pkg:
//      skeleton type codes (MAC=4'd5)
//      FSM state enum {IDLE, ISSUE, DRAIN}
//      read-map offset helpers
//      sat/wrap function
//  - Sub-module mac_mult_pipe_signed (BITWIDTH, MULT_PIPE):
//      registered signed multiplier with a valid-in/valid-out pipe.
//      This is the DUT replacement point.
// TESTING (defaults, MULT_PIPE=2)
//  1. Assert RSTN=0 mid-clock.
//     -> RDY=1 and DATA_OUT=0 immediately.
//     -> DATA_HEAD=26'h150_0510.
//  2. Load A=1..8 and B=2 (all), then pulse the trigger.
//     -> RDY low 11 cycles.
//     -> read ADR0=16'h0048, ADR1=11, ADR2=0.
//  3. Load A0=-128, B0=-128, all other operands 0.
//     -> ADR0=16'h4000, ovf=0.
//  4. Load all A=127, B=127.
//     -> wrap build: ADR0=16'hF808, ovf=1.
//     -> SAT build: ADR0=16'h7FFF.
//     -> with A=-128, B=127 instead: 16'h8000.
//  5. Mid-run: second trigger and write to A0 are ignored (result unchanged).
//     -> then EN=0 for 1 cycle: RDY=1, ADR0 reads 0.
//  6. Async RSTN pulse during DRAIN.
//     -> IDLE, counters=0, operand RAM=0.
//     -> a new run from fresh writes is correct.

Source files
------------

// File: rtl/skeleton_pkg.sv
// ============================================================================
// Module   : skeleton_pkg
// Brief    : Shared types, constants and helpers for the skeleton_mac test
//            skeleton: skeleton type codes, FSM state encoding, read-map
//            offsets and the accumulator saturate/wrap function.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package skeleton_pkg;

    // Skeleton type code reported in the metadata word
    localparam logic [3:0] c_SKEL_TYPE_MAC = 4'd5;
    // Skeleton layout revision reported in the metadata word
    localparam logic [5:0] c_SKEL_REV      = 6'd1;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Number of bus words needed to present the accumulator
    function automatic int unsigned acc_words(input int unsigned acc_w,
                                              input int unsigned sys_w);
        return (acc_w + sys_w - 1) / sys_w;
    endfunction

    // Read-map address of the busy cycle counter
    function automatic int unsigned rd_adr_count(input int unsigned n_acc_words);
        return n_acc_words;
    endfunction

    // Read-map address of the status word
    function automatic int unsigned rd_adr_status(input int unsigned n_acc_words);
        return n_acc_words + 1;
    endfunction

    // True when v is representable as a w-bit two's complement value
    function automatic logic acc_fits(input logic signed [63:0] v,
                                      input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v >= lo) && (v <= hi);
    endfunction

    // Bring an out-of-range sum back into w bits, either clamping to the
    // nearest rail (sat=1) or keeping the low w bits (sat=0)
    function automatic logic signed [63:0] acc_fold(input logic signed [63:0] v,
                                                    input int unsigned        w,
                                                    input logic               sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if ((v >= lo) && (v <= hi)) begin
            return v;
        end else if (sat) begin
            return (v < 0) ? lo : hi;
        end else begin
            return (v <<< (64 - w)) >>> (64 - w);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_mult_pipe_signed.sv
// ============================================================================
// Module   : mac_mult_pipe_signed
// Brief    : Registered signed multiplier with MULT_PIPE register stages and
//            a matching valid pipe. This is the point where the real DUT is
//            swapped in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_mult_pipe_signed #(
    parameter int BITWIDTH  = 8,
    parameter int MULT_PIPE = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         clr_i,
    input  logic                         valid_i,
    input  logic signed [BITWIDTH-1:0]   a_i,
    input  logic signed [BITWIDTH-1:0]   b_i,
    output logic signed [2*BITWIDTH-1:0] prod_o,
    output logic                         valid_o
);

    logic signed [2*BITWIDTH-1:0] w_prod;
    logic signed [2*BITWIDTH-1:0] prod_q [MULT_PIPE];
    logic        [MULT_PIPE-1:0]  vld_q;

    // Full-width signed product of the two operands
    assign w_prod = (2*BITWIDTH)'(a_i) * (2*BITWIDTH)'(b_i);

    // Product and valid shift through the stages together; a clear only
    // needs to kill the valids so no stale product is ever accumulated
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < MULT_PIPE; s++) begin
                prod_q[s] <= '0;
            end
            vld_q <= '0;
        end else if (clr_i) begin
            for (int s = 0; s < MULT_PIPE; s++) begin
                prod_q[s] <= '0;
            end
            vld_q <= '0;
        end else begin
            prod_q[0] <= w_prod;
            vld_q[0]  <= valid_i;
            for (int s = 1; s < MULT_PIPE; s++) begin
                prod_q[s] <= prod_q[s-1];
                vld_q[s]  <= vld_q[s-1];
            end
        end
    end

    assign prod_o  = prod_q[MULT_PIPE-1];
    assign valid_o = vld_q[MULT_PIPE-1];

endmodule

`default_nettype wire

// File: rtl/skeleton_mac.sv
// ============================================================================
// Module   : skeleton_mac
// Brief    : On-device test skeleton for a pipelined signed MAC. The host
//            loads NUM_PAIRS operand pairs over the ADR/RnW bus, fires
//            TRGG_START_CALC, and reads back accumulator, busy cycle count
//            and overflow status.
// Config   : SKELETON_MAC_SATURATE_EN - when defined the accumulator clamps
//            on overflow; otherwise it wraps. ovf is sticky in both builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skeleton_mac
    import skeleton_pkg::*;
#(
    parameter int BITWIDTH_IN   = 8,
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_HEAD = 26,
    parameter int BITWIDTH_ADR  = 6,
    parameter int NUM_PAIRS     = 8,
    parameter int BITWIDTH_ACC  = 16,
    parameter int MULT_PIPE     = 2
) (
    input  logic                     CLK_SYS,
    input  logic                     RSTN,
    input  logic                     EN,
    input  logic                     TRGG_START_CALC,
    input  logic                     RnW,
    input  logic [BITWIDTH_ADR-1:0]  ADR,
    input  logic [BITWIDTH_SYS-1:0]  DATA_IN,
    output logic [BITWIDTH_SYS-1:0]  DATA_OUT,
    output logic [BITWIDTH_HEAD-1:0] DATA_HEAD,
    output logic                     RDY
);

    localparam int c_ACC_WORDS = acc_words(BITWIDTH_ACC, BITWIDTH_SYS);
    localparam int c_ACC_EXT_W = c_ACC_WORDS * BITWIDTH_SYS;
    localparam int c_IDX_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int c_PH_W      = $clog2(MULT_PIPE + 1);
    localparam int c_PROD_W    = 2 * BITWIDTH_IN;

    localparam logic [c_IDX_W-1:0]      c_LAST_IDX = c_IDX_W'(NUM_PAIRS - 1);
    localparam logic [c_PH_W-1:0]       c_LAST_PH  = c_PH_W'(MULT_PIPE);
    localparam logic [BITWIDTH_ADR-1:0] c_ADR_CNT  = BITWIDTH_ADR'(rd_adr_count(c_ACC_WORDS));
    localparam logic [BITWIDTH_ADR-1:0] c_ADR_STAT = BITWIDTH_ADR'(rd_adr_status(c_ACC_WORDS));
    localparam logic [5:0]              c_PAIRS2   = 6'(2 * NUM_PAIRS);

`ifdef SKELETON_MAC_SATURATE_EN
    localparam logic c_SAT = 1'b1;
`else
    localparam logic c_SAT = 1'b0;
`endif

    // Sequencer registers
    state_e                    state_q;
    logic                      rdy_q;
    logic [c_IDX_W-1:0]        idx_q;
    logic [c_PH_W-1:0]         phase_q;
    logic [BITWIDTH_SYS-1:0]   count_q;

    // Operand RAM
    logic signed [BITWIDTH_IN-1:0] opa_q [NUM_PAIRS];
    logic signed [BITWIDTH_IN-1:0] opb_q [NUM_PAIRS];

    // Accumulator and status
    logic signed [BITWIDTH_ACC-1:0] acc_q;
    logic signed [BITWIDTH_ACC-1:0] acc_d;
    logic                           ovf_q;
    logic                           ovf_d;

    // Read port
    logic [BITWIDTH_SYS-1:0]  data_out_q;
    logic [BITWIDTH_SYS-1:0]  w_rd_data;
    logic signed [c_ACC_EXT_W-1:0] w_acc_ext;

    // Datapath wires
    logic                          w_start;
    logic                          w_wr_en;
    logic signed [BITWIDTH_IN-1:0] w_wr_opnd;
    logic signed [BITWIDTH_IN-1:0] w_op_a;
    logic signed [BITWIDTH_IN-1:0] w_op_b;
    logic                          w_issue;
    logic signed [c_PROD_W-1:0]    w_mult_prod;
    logic                          w_mult_vld;
    logic signed [63:0]            w_sum;
    logic                          w_unused_data;

    // Only the MSB-aligned operand field of the write bus is used
    assign w_unused_data = &{1'b0, DATA_IN};

    assign w_start   = (state_q == ST_IDLE) && TRGG_START_CALC;
    assign w_wr_en   = (state_q == ST_IDLE) && !RnW;
    assign w_wr_opnd = DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN];
    assign w_issue   = (state_q == ST_ISSUE);
    assign w_op_a    = opa_q[idx_q];
    assign w_op_b    = opb_q[idx_q];

    // Sequencer: IDLE -> ISSUE (one pair per cycle) -> DRAIN (pipe flush) -> IDLE
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            idx_q   <= '0;
            phase_q <= '0;
            count_q <= '0;
        end else if (!EN) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            idx_q   <= '0;
            phase_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (TRGG_START_CALC) begin
                        state_q <= ST_ISSUE;
                        rdy_q   <= 1'b0;
                        idx_q   <= '0;
                        count_q <= '0;
                    end
                end
                ST_ISSUE: begin
                    count_q <= count_q + BITWIDTH_SYS'(1);
                    if (idx_q == c_LAST_IDX) begin
                        state_q <= ST_DRAIN;
                        phase_q <= '0;
                    end else begin
                        idx_q <= idx_q + c_IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    count_q <= count_q + BITWIDTH_SYS'(1);
                    if (phase_q == c_LAST_PH) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
                        phase_q <= phase_q + c_PH_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    // Operand RAM: host writes land only while idle; A at 0..N-1, B at N..2N-1
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
                opa_q[i] <= '0;
                opb_q[i] <= '0;
            end
        end else if (!EN) begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
                opa_q[i] <= '0;
                opb_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
                if (ADR == BITWIDTH_ADR'(i)) begin
                    opa_q[i] <= w_wr_opnd;
                end
                if (ADR == BITWIDTH_ADR'(NUM_PAIRS + i)) begin
                    opb_q[i] <= w_wr_opnd;
                end
            end
        end
    end

    mac_mult_pipe_signed #(
        .BITWIDTH  (BITWIDTH_IN),
        .MULT_PIPE (MULT_PIPE)
    ) u_mult (
        .clk_i   (CLK_SYS),
        .rst_n_i (RSTN),
        .clr_i   (!EN),
        .valid_i (w_issue),
        .a_i     (w_op_a),
        .b_i     (w_op_b),
        .prod_o  (w_mult_prod),
        .valid_o (w_mult_vld)
    );

    // Next accumulator value: wide sum, then range check and clamp or wrap
    assign w_sum = 64'(acc_q) + 64'(w_mult_prod);

    always_comb begin
        acc_d = BITWIDTH_ACC'(acc_fold(w_sum, BITWIDTH_ACC, c_SAT));
        ovf_d = ovf_q | ~acc_fits(w_sum, BITWIDTH_ACC);
    end

    // Accumulator: cleared on run start, adds each valid product leaving the multiplier
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (!EN) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (w_start) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (w_mult_vld) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    // Read map decode: accumulator words, busy count, status, zero elsewhere
    assign w_acc_ext = c_ACC_EXT_W'(acc_q);

    always_comb begin
        w_rd_data = '0;
        for (int w = 0; w < c_ACC_WORDS; w++) begin
            if (ADR == BITWIDTH_ADR'(w)) begin
                w_rd_data = w_acc_ext[w*BITWIDTH_SYS +: BITWIDTH_SYS];
            end
        end
        if (ADR == c_ADR_CNT) begin
            w_rd_data = count_q;
        end
        if (ADR == c_ADR_STAT) begin
            w_rd_data = {{(BITWIDTH_SYS-1){1'b0}}, ovf_q};
        end
    end

    // Registered read data; holds its last value while the bus is writing
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            data_out_q <= '0;
        end else if (!EN) begin
            data_out_q <= '0;
        end else if (RnW) begin
            data_out_q <= w_rd_data;
        end
    end

    assign DATA_OUT  = data_out_q;
    assign RDY       = rdy_q;
    assign DATA_HEAD = BITWIDTH_HEAD'({c_SKEL_TYPE_MAC, c_PAIRS2, c_SKEL_REV,
                                       5'(BITWIDTH_IN), 5'(BITWIDTH_ACC)});

endmodule

`default_nettype wire

// File: tb/tb_skeleton_mac.sv
// ============================================================================
// Module   : tb_skeleton_mac
// Brief    : Self-checking bench for skeleton_mac with a behavioural model of
//            the multiply-accumulate run (plain integer arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skeleton_mac;

    localparam int N    = 8;
    localparam int P    = 2;
    localparam int SYS  = 16;
    localparam int ACC  = 16;
    localparam int ADRW = 6;
    localparam int HEAD = 26;
    localparam int BUSY = N + P + 1;

    logic            clk  = 1'b0;
    logic            rstn = 1'b1;
    logic            en   = 1'b1;
    logic            trg  = 1'b0;
    logic            rnw  = 1'b1;
    logic [ADRW-1:0] adr  = '1;
    logic [SYS-1:0]  din  = '0;
    logic [SYS-1:0]  dout;
    logic [HEAD-1:0] head;
    logic            rdy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int ma [N];
    int mb [N];

    skeleton_mac #(
        .BITWIDTH_IN   (8),
        .BITWIDTH_SYS  (SYS),
        .BITWIDTH_HEAD (HEAD),
        .BITWIDTH_ADR  (ADRW),
        .NUM_PAIRS     (N),
        .BITWIDTH_ACC  (ACC),
        .MULT_PIPE     (P)
    ) dut (
        .CLK_SYS         (clk),
        .RSTN            (rstn),
        .EN              (en),
        .TRGG_START_CALC (trg),
        .RnW             (rnw),
        .ADR             (adr),
        .DATA_IN         (din),
        .DATA_OUT        (dout),
        .DATA_HEAD       (head),
        .RDY             (rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of signed products with sticky overflow, clamp or wrap
    function automatic void model_run(output int acc, output int ovf);
        longint s;
        longint hi;
        longint lo;
        longint m;
        hi  = (longint'(1) <<< (ACC - 1)) - 1;
        lo  = -hi - 1;
        m   = longint'(1) <<< ACC;
        acc = 0;
        ovf = 0;
        for (int i = 0; i < N; i++) begin
            s = longint'(acc) + longint'(ma[i]) * longint'(mb[i]);
            if (s > hi || s < lo) begin
                ovf = 1;
`ifdef SKELETON_MAC_SATURATE_EN
                s = (s > 0) ? hi : lo;
`else
                s = ((s % m) + m) % m;
                if (s > hi) s = s - m;
`endif
            end
            acc = int'(s);
        end
    endfunction

    function automatic int rnd8();
        byte b;
        b = byte'($urandom);
        return int'(b);
    endfunction

    // All bus tasks start and end at a falling edge
    task automatic wr(input int a, input int val);
        rnw = 1'b0;
        adr = ADRW'(a);
        din = {8'(val), 8'($urandom)};
        @(negedge clk);
        rnw = 1'b1;
        adr = '1;
    endtask

    task automatic rd(input int a, output logic [SYS-1:0] val);
        rnw = 1'b1;
        adr = ADRW'(a);
        @(negedge clk);
        val = dout;
        adr = '1;
    endtask

    task automatic load_model();
        for (int i = 0; i < N; i++) wr(i, ma[i]);
        for (int i = 0; i < N; i++) wr(N + i, mb[i]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
    endtask

    task automatic run(input string tag);
        int low;
        trg = 1'b1;
        @(negedge clk);
        trg = 1'b0;
        low = 0;
        while (rdy !== 1'b1 && low < 200) begin
            low++;
            @(negedge clk);
        end
        chk({tag, "_busy"}, 32'(low), 32'(BUSY));
    endtask

    task automatic check_result(input string tag);
        int acc;
        int ovf;
        logic [SYS-1:0] v;
        model_run(acc, ovf);
        rd(0, v); chk({tag, "_acc"}, 32'(v), 32'(acc) & 32'h0000_FFFF);
        rd(1, v); chk({tag, "_cnt"}, 32'(v), 32'(BUSY));
        rd(2, v); chk({tag, "_ovf"}, 32'(v), 32'(ovf));
    endtask

    initial begin
        logic [SYS-1:0] v;
        int low;

        // 1. asynchronous reset mid-clock
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_rdy",  32'(rdy),  32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_head", 32'(head), 32'h0150_0510);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rd(0, v); chk("rst_acc", 32'(v), 32'd0);
        rd(1, v); chk("rst_cnt", 32'(v), 32'd0);
        rd(2, v); chk("rst_ovf", 32'(v), 32'd0);
        clear_model();

        // 2. A=1..8, B=2
        for (int i = 0; i < N; i++) begin
            ma[i] = i + 1;
            mb[i] = 2;
        end
        load_model();
        run("t2");
        check_result("t2");
        rd(0, v); chk("t2_lit", 32'(v), 32'h48);

        // 3. single max-magnitude product
        clear_model();
        ma[0] = -128;
        mb[0] = -128;
        load_model();
        run("t3");
        check_result("t3");

        // 4. overflow: all 127 * 127, then -128 * 127
        for (int i = 0; i < N; i++) begin
            ma[i] = 127;
            mb[i] = 127;
        end
        load_model();
        run("t4");
        check_result("t4");
        rd(0, v);
`ifdef SKELETON_MAC_SATURATE_EN
        chk("t4_lit", 32'(v), 32'h7FFF);
`else
        chk("t4_lit", 32'(v), 32'hF808);
`endif
        for (int i = 0; i < N; i++) ma[i] = -128;
        load_model();
        run("t4n");
        check_result("t4n");

        // unmapped reads return 0, unmapped writes are ignored
        rd(3, v);  chk("rd_adr3",  32'(v), 32'd0);
        rd(63, v); chk("rd_adr63", 32'(v), 32'd0);

        // randomized runs, extremes mixed in on odd iterations
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) begin
                if (it % 2 == 1) begin
                    ma[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
                    mb[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
                end else begin
                    ma[i] = rnd8();
                    mb[i] = rnd8();
                end
            end
            load_model();
            wr($urandom_range(2 * N, 63), rnd8());
            run($sformatf("rnd%0d", it));
            check_result($sformatf("rnd%0d", it));
        end

        // 5. mid-run trigger and write to A0 are ignored
        for (int i = 0; i < N; i++) begin
            ma[i] = rnd8();
            mb[i] = rnd8();
        end
        load_model();
        trg = 1'b1;
        @(negedge clk);
        trg = 1'b0;
        repeat (3) @(negedge clk);
        trg = 1'b1;
        rnw = 1'b0;
        adr = '0;
        din = {8'(ma[0] ^ 8'h5A), 8'h00};
        @(negedge clk);
        trg = 1'b0;
        rnw = 1'b1;
        adr = '1;
        low = 4;
        while (rdy !== 1'b1 && low < 200) begin
            low++;
            @(negedge clk);
        end
        chk("t5_busy", 32'(low), 32'(BUSY));
        check_result("t5");

        // 5b. EN low for one cycle mid-run clears everything
        trg = 1'b1;
        @(negedge clk);
        trg = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        chk("t5_en_rdy", 32'(rdy), 32'd1);
        rd(0, v); chk("t5_en_acc", 32'(v), 32'd0);
        rd(1, v); chk("t5_en_cnt", 32'(v), 32'd0);
        clear_model();
        run("t5_ram");
        check_result("t5_ram");

        // 6. asynchronous reset during DRAIN
        for (int i = 0; i < N; i++) begin
            ma[i] = rnd8();
            mb[i] = rnd8();
        end
        load_model();
        trg = 1'b1;
        @(negedge clk);
        trg = 1'b0;
        repeat (9) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rdy",  32'(rdy),  32'd1);
        chk("t6_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        rd(0, v); chk("t6_acc", 32'(v), 32'd0);
        rd(1, v); chk("t6_cnt", 32'(v), 32'd0);
        rd(2, v); chk("t6_ovf", 32'(v), 32'd0);
        clear_model();
        run("t6_ram");
        check_result("t6_ram");
        for (int i = 0; i < N; i++) begin
            ma[i] = rnd8();
            mb[i] = rnd8();
        end
        load_model();
        run("t6_new");
        check_result("t6_new");

        // 7. trigger held across the completion edge is ignored, then re-arms
        trg = 1'b1;
        @(negedge clk);
        trg = 1'b0;
        repeat (10) @(negedge clk);
        trg = 1'b1;
        @(negedge clk);
        trg = 1'b0;
        chk("t7_done_rdy", 32'(rdy), 32'd1);
        @(negedge clk);
        chk("t7_noretrig", 32'(rdy), 32'd1);
        run("t7_rearm");
        check_result("t7_rearm");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
